fu_mul_pipe: RTL and testbench



---
 rtl/fu_mul_pipe_if.sv | 28 ++
 rtl/fu_mul_pipe.sv | 120 ++++++++++++
 tb/tb_fu_mul_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_mul_pipe_if.sv
// Handshake bundle for the pipelined multiply unit: issue side (in_*),
// result side (out_*) and the redirect flush.
interface fu_mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag
    );
endinterface

// File: rtl/fu_mul_pipe.sv
// Fully pipelined RV32M-style multiply unit (MUL/MULH/MULHSU/MULHU) with tag
// pass-through, whole-pipe stall on output back-pressure and synchronous flush.

module fu_mul_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] res_o,
    output logic [TAG_W-1:0] tag_o
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Bubbles advance with the rest of the pipe; nothing is compacted.
    always_comb begin
        vld_d = vld_q;
        res_d = res_q;
        tag_d = tag_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (en_i) begin
            vld_d = vld_i;
            res_d = res_i;
            tag_d = tag_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            res_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            res_q <= res_d;
            tag_q <= tag_d;
        end
    end

    assign vld_o = vld_q;
    assign res_o = res_q;
    assign tag_o = tag_q;
endmodule

module fu_mul_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    fu_mul_pipe_if.slave bus
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic                           stall;
    logic                           accept;
    logic [LATENCY:0]               vld_pipe;
    logic [LATENCY:0][WIDTH-1:0]    res_pipe;
    logic [LATENCY:0][TAG_W-1:0]    tag_pipe;

    logic                           a_sgn, b_sgn;
    logic signed [WIDTH:0]          a_ext, b_ext;
    logic signed [2*WIDTH+1:0]      a_x, b_x, prod;
    logic [WIDTH-1:0]               res0;

    assign stall        = vld_pipe[LATENCY] & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;

    // One (WIDTH+1)-bit signed multiply covers all four variants; only the
    // extension of each operand and the half selected differ.
    always_comb begin
        a_sgn = (bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU);
        b_sgn = (bus.in_op == OP_MULH);
        a_ext = {a_sgn & bus.in_a[WIDTH-1], bus.in_a};
        b_ext = {b_sgn & bus.in_b[WIDTH-1], bus.in_b};
        a_x   = {{(WIDTH+1){a_ext[WIDTH]}}, a_ext};
        b_x   = {{(WIDTH+1){b_ext[WIDTH]}}, b_ext};
        prod  = a_x * b_x;
        res0  = (bus.in_op == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    assign vld_pipe[0] = accept;
    assign res_pipe[0] = res0;
    assign tag_pipe[0] = bus.in_tag;

    for (genvar s = 1; s <= LATENCY; s++) begin : g_stg
        fu_mul_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W)
        ) u_stg (
            .clk     (clk),
            .rst     (rst),
            .flush_i (bus.flush),
            .en_i    (~stall),
            .vld_i   (vld_pipe[s-1]),
            .res_i   (res_pipe[s-1]),
            .tag_i   (tag_pipe[s-1]),
            .vld_o   (vld_pipe[s]),
            .res_o   (res_pipe[s]),
            .tag_o   (tag_pipe[s])
        );
    end

    assign bus.out_valid = vld_pipe[LATENCY];
    assign bus.out_res   = res_pipe[LATENCY];
    assign bus.out_tag   = tag_pipe[LATENCY];
endmodule

// File: tb/tb_fu_mul_pipe.sv
// Bench for fu_mul_pipe: a 32-bit/4-stage and a 16-bit/1-stage instance,
// directed cases plus randomized traffic against an arithmetic reference model.
module tb_fu_mul_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  iv, fl, ordy;
    logic [1:0]  opv [2];
    logic [31:0] av  [2];
    logic [31:0] bv  [2];
    logic [3:0]  tgv [2];
    wire  [1:0]  ov, ir;
    wire  [31:0] ores [2];
    wire  [3:0]  otag [2];

    fu_mul_pipe_if #(.WIDTH(32), .TAG_W(4)) ifa ();
    fu_mul_pipe_if #(.WIDTH(16), .TAG_W(4)) ifb ();

    fu_mul_pipe #(.WIDTH(32), .LATENCY(4), .TAG_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    fu_mul_pipe #(.WIDTH(16), .LATENCY(1), .TAG_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.flush = fl[0];  assign ifa.in_valid = iv[0];  assign ifa.out_ready = ordy[0];
    assign ifa.in_op = opv[0]; assign ifa.in_a = av[0];      assign ifa.in_b = bv[0];
    assign ifa.in_tag = tgv[0];
    assign ifb.flush = fl[1];  assign ifb.in_valid = iv[1];  assign ifb.out_ready = ordy[1];
    assign ifb.in_op = opv[1]; assign ifb.in_a = av[1][15:0]; assign ifb.in_b = bv[1][15:0];
    assign ifb.in_tag = tgv[1];
    assign ov[0] = ifa.out_valid; assign ir[0] = ifa.in_ready;
    assign ov[1] = ifb.out_valid; assign ir[1] = ifb.in_ready;
    assign ores[0] = ifa.out_res; assign ores[1] = {16'h0000, ifb.out_res};
    assign otag[0] = ifa.out_tag; assign otag[1] = ifb.out_tag;

    function automatic int lat(int d);
        return (d == 0) ? 4 : 1;
    endfunction
    function automatic int wid(int d);
        return (d == 0) ? 32 : 16;
    endfunction
    function automatic logic [31:0] wmask(int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] model(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] r;
        logic [31:0] m;
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
        if (op == 2'b01 || op == 2'b10) sa = (sa <<< (64 - w)) >>> (64 - w);
        if (op == 2'b01) sb = (sb <<< (64 - w)) >>> (64 - w);
        p = sa * sb;
        r = (op == 2'b00) ? p : (p >>> w);
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return r[31:0] & m;
    endfunction

    function automatic logic [31:0] pick(int d);
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return (d == 0) ? 32'h8000_0000 : 32'h0000_8000;
            4: return (d == 0) ? 32'h7FFF_FFFF : 32'h0000_7FFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic chk1(string name, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    typedef struct { int d; logic [31:0] res; logic [3:0] tag; } exp_t;
    typedef struct { int d; int tag; int cyc; } log_t;
    exp_t sb[$];
    log_t flog[$];
    log_t alog[$];
    logic [1:0]  pstall = 2'b00;
    logic [31:0] pres [2];
    logic [3:0]  ptag [2];

    function automatic int pending(int d);
        int n = 0;
        foreach (sb[i]) if (sb[i].d == d) n++;
        return n;
    endfunction

    task automatic purge(int d);
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
    endtask

    task automatic mon(int d);
        int idx;
        if (rst) begin
            purge(d);
            pstall[d] = 1'b0;
            chk1("rst_valid", ov[d], 1'b0);
            return;
        end
        chk1("in_ready_rule", ir[d], ~(ov[d] & ~ordy[d]) & ~fl[d]);
        if (pstall[d]) begin
            chk1("hold_valid", ov[d], 1'b1);
            chk("hold_res", ores[d], pres[d]);
            chk("hold_tag", {28'h0, otag[d]}, {28'h0, ptag[d]});
        end
        pstall[d] = ov[d] & ~ordy[d] & ~fl[d];
        pres[d] = ores[d];
        ptag[d] = otag[d];
        if (fl[d]) begin
            purge(d);
            return;
        end
        if (ov[d] && ordy[d]) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) if (sb[i].d == d) begin idx = i; break; end
            chk1("out_has_expected", idx >= 0, 1'b1);
            if (idx >= 0) begin
                chk("sb_res", ores[d], sb[idx].res);
                chk("sb_tag", {28'h0, otag[d]}, {28'h0, sb[idx].tag});
                sb.delete(idx);
            end
            flog.push_back('{d, int'(otag[d]), cyc});
        end
        if (iv[d] && ir[d]) begin
            sb.push_back('{d, model(wid(d), opv[d], av[d] & wmask(d), bv[d] & wmask(d)), tgv[d]});
            alog.push_back('{d, int'(tgv[d]), cyc});
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic send(int d, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] tag);
        iv[d] = 1'b1; opv[d] = op; av[d] = a & wmask(d); bv[d] = b & wmask(d); tgv[d] = tag;
        @(negedge clk);
        chk1("send_ready", ir[d], 1'b1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_res(int d, logic [31:0] exp, logic [3:0] tag);
        for (int k = 1; k <= lat(d); k++) begin
            @(negedge clk);
            if (k < lat(d)) chk1("early_valid", ov[d], 1'b0);
        end
        chk1("lat_valid", ov[d], 1'b1);
        chk("lat_res", ores[d], exp);
        chk("lat_tag", {28'h0, otag[d]}, {28'h0, tag});
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(int d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov[d]) break;
        end
        chk1("wait_valid", ov[d], 1'b1);
    endtask

    typedef struct {
        logic [1:0] op; logic [31:0] a32, b32, e32; logic [15:0] a16, b16, e16;
    } dcase_t;
    dcase_t dc [8] = '{
        '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 16'h0007, 16'hFFFD, 16'hFFEB},
        '{2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 16'h0007, 16'hFFFD, 16'hFFFF},
        '{2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 16'h0007, 16'hFFFD, 16'h0006},
        '{2'b10, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 16'h0007, 16'hFFFD, 16'h0006},
        '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 16'h8000, 16'h8000, 16'h4000},
        '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 16'h8000, 16'hFFFF, 16'h8000},
        '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE},
        '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 16'hFFFF, 16'hFFFF, 16'h0001}
    };

    task automatic run(int d);
        int n;
        logic [31:0] r0, a, b;
        logic [3:0]  t0;
        logic [1:0]  op;

        // directed arithmetic with exact latency
        for (int i = 0; i < 8; i++) begin
            send(d, dc[i].op, (d == 0) ? dc[i].a32 : {16'h0, dc[i].a16},
                 (d == 0) ? dc[i].b32 : {16'h0, dc[i].b16}, 4'(i + 3));
            wait_res(d, (d == 0) ? dc[i].e32 : {16'h0, dc[i].e16}, 4'(i + 3));
        end

        // back-to-back
        flog.delete(); alog.delete();
        for (int i = 0; i < 8; i++) send(d, 2'($urandom), pick(d), pick(d), 4'(i));
        repeat (lat(d) + 2) @(negedge clk);
        chk("b2b_count", 32'(flog.size()), 32'd8);
        if (flog.size() == 8 && alog.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk("b2b_tag", 32'(flog[i].tag), 32'(i));
                chk("b2b_cyc", 32'(flog[i].cyc), 32'(alog[0].cyc + lat(d) + i));
            end
        @(posedge clk); #1;

        // back-pressure
        n = (lat(d) < 3) ? lat(d) : 3;
        flog.delete(); ordy[d] = 1'b0;
        for (int i = 0; i < n; i++) send(d, 2'($urandom), pick(d), pick(d), 4'(8 + i));
        wait_valid(d);
        r0 = ores[d]; t0 = otag[d];
        @(posedge clk); #1;
        iv[d] = 1'b1; opv[d] = 2'($urandom); av[d] = pick(d) & wmask(d); bv[d] = pick(d) & wmask(d); tgv[d] = 4'd11;
        repeat (5) begin
            @(negedge clk);
            chk1("bp_valid", ov[d], 1'b1);
            chk1("bp_ready", ir[d], 1'b0);
            chk("bp_res", ores[d], r0);
            chk("bp_tag", {28'h0, otag[d]}, {28'h0, t0});
        end
        @(posedge clk); #1; ordy[d] = 1'b1;
        @(posedge clk); #1; iv[d] = 1'b0;
        repeat (lat(d) + 3) @(negedge clk);
        chk("bp_count", 32'(flog.size()), 32'(n + 1));
        if (flog.size() == n + 1) begin
            for (int i = 0; i < n; i++) begin
                chk("bp_order", 32'(flog[i].tag), 32'(8 + i));
                chk("bp_drain_cyc", 32'(flog[i].cyc), 32'(flog[0].cyc + i));
            end
            chk("bp_late_tag", 32'(flog[n].tag), 32'd11);
        end
        @(posedge clk); #1;

        // flush with a stalled result presented
        n = (lat(d) < 4) ? lat(d) : 4;
        flog.delete(); ordy[d] = 1'b0;
        for (int i = 0; i < n; i++) send(d, 2'($urandom), pick(d), pick(d), 4'(i));
        wait_valid(d);
        @(posedge clk); #1;
        fl[d] = 1'b1; iv[d] = 1'b1; tgv[d] = 4'd12;
        @(negedge clk);
        chk1("fl_ready", ir[d], 1'b0);
        @(posedge clk); #1;
        fl[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b1;
        chk1("fl_valid", ov[d], 1'b0);
        op = 2'($urandom); a = pick(d) & wmask(d); b = pick(d) & wmask(d);
        send(d, op, a, b, 4'd13);
        wait_res(d, model(wid(d), op, a, b), 4'd13);
        repeat (4) @(negedge clk);
        chk("fl_count", 32'(flog.size()), 32'd1);
        @(posedge clk); #1;

        // asynchronous reset mid-stream
        n = (lat(d) < 3) ? lat(d) : 3;
        ordy[d] = 1'b0;
        for (int i = 0; i < n; i++) send(d, 2'($urandom), pick(d), pick(d), 4'(i));
        wait_valid(d);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk1("rst_async_valid", ov[d], 1'b0);
        chk("rst_async_res", ores[d], 32'h0);
        chk("rst_async_tag", {28'h0, otag[d]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; ordy[d] = 1'b1; flog.delete();
        repeat (lat(d) + 4) begin
            @(negedge clk);
            chk1("rst_no_out", ov[d], 1'b0);
        end
        chk("rst_count", 32'(flog.size()), 32'd0);
        @(posedge clk); #1;

        // randomized traffic with stalls and flushes
        for (int i = 0; i < 300; i++) begin
            iv[d] = 1'($urandom); opv[d] = 2'($urandom);
            av[d] = pick(d) & wmask(d); bv[d] = pick(d) & wmask(d); tgv[d] = 4'($urandom);
            ordy[d] = ($urandom_range(0, 3) != 0);
            fl[d] = ($urandom_range(0, 24) == 0);
            @(posedge clk); #1;
        end
        iv[d] = 1'b0; fl[d] = 1'b0; ordy[d] = 1'b1;
        repeat (lat(d) + 3) @(negedge clk);
        chk("rnd_drain", 32'(pending(d)), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        iv = 2'b00; fl = 2'b00; ordy = 2'b11;
        for (int d = 0; d < 2; d++) begin
            opv[d] = 2'b00; av[d] = 32'h0; bv[d] = 32'h0; tgv[d] = 4'h0;
            pres[d] = 32'h0; ptag[d] = 4'h0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk1("reset_valid", ov[d], 1'b0);
            chk("reset_res", ores[d], 32'h0);
            chk("reset_tag", {28'h0, otag[d]}, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1("idle_valid", ov[d], 1'b0);
            chk1("idle_ready", ir[d], 1'b1);
        end
        @(posedge clk); #1;
        run(0);
        run(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
